// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and the downstream
// sequence detectors: FSM state encoding, the default SYNC pattern and the
// even-parity helper. The detector imports SYNC_DEF from here so both ends
// agree on the frame preamble.
package serial_pkg;

    localparam int             SYNC_W_DEF = 4;
    localparam logic [3:0]     SYNC_DEF   = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_DATA   = 2'd2,
        ST_PARITY = 2'd3
    } state_e;

    // Even parity over up to 64 bits; callers zero-extend narrower words,
    // which leaves the XOR reduction unchanged.
    function automatic logic parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Loadable parallel-in / serial-out shift register, MSB first.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset, clears the register
//   load_i  - capture d_i (has priority over shift_i)
//   shift_i - shift left by one, filling with 0
//   d_i     - parallel word
//   msb_o   - current MSB (next bit to send)
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    output logic         msb_o
);

    logic [W-1:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (load_i) begin
            sh_q <= d_i;
        end else if (shift_i) begin
            sh_q <= {sh_q[W-2:0], 1'b0};
        end
    end

    assign msb_o = sh_q[W-1];

endmodule

// File: rtl/serial_seq_tx.sv
// Parallel-to-serial frame transmitter. A word accepted on load/ready is sent
// on op as SYNC pattern (MSB first), payload (MSB first) and, optionally, an
// even-parity bit. The FSM state always describes the bit currently on op.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   din        - payload, captured on acceptance only
//   load       - send request
//   ready      - a load is accepted this cycle (idle or last frame bit)
//   op         - registered serial output
//   busy       - a frame bit is on op
//   frame_done - high during the final bit of a frame
module serial_seq_tx
    import serial_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC      = SYNC_DEF,
    parameter int                PARITY_EN = 0,
    parameter logic              IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              op,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAXW = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CW   = $clog2(MAXW + 1);
    localparam bit PAR  = (PARITY_EN != 0);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;      // bits left in the current phase, incl. the one on op
    logic            par_q;
    logic            op_q, busy_q, done_q;
    logic            last_bit;
    logic            accept;
    logic            shift_en;
    logic            pay_msb;
    logic [SYNC_W-1:0] sync_sh;

    // Final bit of the frame: either the parity bit or the last payload bit.
    assign last_bit = (state_q == ST_PARITY) ||
                      (!PAR && state_q == ST_DATA && cnt_q == CW'(1));
    assign ready    = (state_q == ST_IDLE) || last_bit;
    assign accept   = load && ready;

    // Next sync bit to present while cnt_q >= 2: index cnt_q-2.
    assign sync_sh  = SYNC >> (cnt_q - CW'(2));

    // The payload MSB is consumed when it moves onto op: at the SYNC->DATA
    // boundary and on every DATA bit except the last.
    assign shift_en = !accept &&
                      ((state_q == ST_SYNC && cnt_q == CW'(1)) ||
                       (state_q == ST_DATA && cnt_q >  CW'(1)));

    piso_shift #(.W(DATA_W)) u_piso (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (accept),
        .shift_i (shift_en),
        .d_i     (din),
        .msb_o   (pay_msb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            op_q    <= IDLE_BIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state_q <= ST_SYNC;
                cnt_q   <= CW'(SYNC_W);
                par_q   <= parity(64'(din));
                op_q    <= SYNC[SYNC_W-1];
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        if (cnt_q > CW'(1)) begin
                            cnt_q <= cnt_q - CW'(1);
                            op_q  <= sync_sh[0];
                        end else begin
                            state_q <= ST_DATA;
                            cnt_q   <= CW'(DATA_W);
                            op_q    <= pay_msb;
                            done_q  <= (DATA_W == 1) && !PAR;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q > CW'(1)) begin
                            cnt_q  <= cnt_q - CW'(1);
                            op_q   <= pay_msb;
                            done_q <= !PAR && (cnt_q == CW'(2));
                        end else if (PAR) begin
                            state_q <= ST_PARITY;
                            cnt_q   <= CW'(1);
                            op_q    <= par_q;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            op_q    <= IDLE_BIT;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_PARITY: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        op_q    <= IDLE_BIT;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        op_q    <= IDLE_BIT;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign op         = op_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Directed bench: u0 has no parity, u1 appends even parity. Inputs change and
// outputs are sampled on the falling edge.
module tb_serial_seq_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din0, din1;
    logic       load0, load1;
    logic       ready0, op0, busy0, done0;
    logic       ready1, op1, busy1, done1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_seq_tx #(.PARITY_EN(0)) u0 (
        .clk(clk), .reset(rst_n), .din(din0), .load(load0),
        .ready(ready0), .op(op0), .busy(busy0), .frame_done(done0)
    );

    serial_seq_tx #(.PARITY_EN(1)) u1 (
        .clk(clk), .reset(rst_n), .din(din1), .load(load1),
        .ready(ready1), .op(op1), .busy(busy1), .frame_done(done1)
    );

    task automatic test_reset;
        rst_n = 1'b0; din0 = 8'h00; din1 = 8'h00; load0 = 1'b0; load1 = 1'b0;
        #2;
        checks++; if ({op0, busy0, ready0, done0} !== 4'b0010) begin
            errors++; $display("FAIL reset_u0 got=%b exp=0010", {op0, busy0, ready0, done0});
        end
        checks++; if ({op1, busy1, ready1, done1} !== 4'b0010) begin
            errors++; $display("FAIL reset_u1 got=%b exp=0010", {op1, busy1, ready1, done1});
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_a5;
        logic [11:0] exp;
        exp = 12'b1011_1010_0101;
        checks++; if (ready0 !== 1'b1) begin
            errors++; $display("FAIL a5_ready got=%b exp=1", ready0);
        end
        din0 = 8'hA5; load0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load0 = 1'b0; din0 = 8'h5A;  // later din changes must not matter
            checks++; if ({op0, busy0, done0} !== {exp[11-i], 1'b1, (i == 11)}) begin
                errors++; $display("FAIL a5_bit%0d got=%b exp=%b", i, {op0, busy0, done0}, {exp[11-i], 1'b1, (i == 11)});
            end
        end
        @(negedge clk);
        checks++; if ({op0, busy0, ready0, done0} !== 4'b0010) begin
            errors++; $display("FAIL a5_after got=%b exp=0010", {op0, busy0, ready0, done0});
        end
    endtask

    task automatic test_parity;
        logic [12:0] exp;
        exp = 13'b1011_0000_0111_1;
        @(negedge clk);
        din1 = 8'h07; load1 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            load1 = 1'b0;
            checks++; if ({op1, busy1, done1, ready1} !== {exp[12-i], 1'b1, (i == 12), (i == 12)}) begin
                errors++; $display("FAIL par_bit%0d got=%b exp=%b", i, {op1, busy1, done1, ready1}, {exp[12-i], 1'b1, (i == 12), (i == 12)});
            end
        end
        @(negedge clk);
        checks++; if ({op1, busy1, done1} !== 3'b000) begin
            errors++; $display("FAIL par_after got=%b exp=000", {op1, busy1, done1});
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp_a, exp_b;
        exp_a = 12'b1011_1010_0101;
        exp_b = 12'b1011_0011_1100;
        @(negedge clk);
        din0 = 8'hA5; load0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load0 = 1'b0;
            checks++; if (op0 !== exp_a[11-i]) begin
                errors++; $display("FAIL b2b_a_bit%0d got=%b exp=%b", i, op0, exp_a[11-i]);
            end
            if (i == 11) begin
                checks++; if ({done0, ready0} !== 2'b11) begin
                    errors++; $display("FAIL b2b_last got=%b exp=11", {done0, ready0});
                end
                din0 = 8'h3C; load0 = 1'b1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load0 = 1'b0;
            checks++; if ({op0, busy0, done0} !== {exp_b[11-i], 1'b1, (i == 11)}) begin
                errors++; $display("FAIL b2b_b_bit%0d got=%b exp=%b", i, {op0, busy0, done0}, {exp_b[11-i], 1'b1, (i == 11)});
            end
        end
        @(negedge clk);
        checks++; if ({op0, busy0} !== 2'b00) begin
            errors++; $display("FAIL b2b_after got=%b exp=00", {op0, busy0});
        end
    endtask

    task automatic test_load_ignored;
        logic [11:0] exp;
        exp = 12'b1011_1010_0101;
        @(negedge clk);
        din0 = 8'hA5; load0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load0 = (i == 1);
            din0  = (i == 1) ? 8'hFF : 8'h00;
            if (i == 1) begin
                checks++; if (ready0 !== 1'b0) begin
                    errors++; $display("FAIL ign_ready got=%b exp=0", ready0);
                end
            end
            checks++; if (op0 !== exp[11-i]) begin
                errors++; $display("FAIL ign_bit%0d got=%b exp=%b", i, op0, exp[11-i]);
            end
        end
        load0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({op0, busy0, done0} !== 3'b000) begin
                errors++; $display("FAIL ign_idle%0d got=%b exp=000", i, {op0, busy0, done0});
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [11:0] exp;
        exp = 12'b1011_0000_0001;
        @(negedge clk);
        din0 = 8'hA5; load0 = 1'b1;
        for (int i = 0; i < 10; i++) begin   // cycle 10 carries DATA bit 6
            @(negedge clk);
            load0 = 1'b0;
        end
        checks++; if (busy0 !== 1'b1) begin
            errors++; $display("FAIL abort_busy_pre got=%b exp=1", busy0);
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({op0, busy0, ready0, done0} !== 4'b0010) begin
            errors++; $display("FAIL abort_async got=%b exp=0010", {op0, busy0, ready0, done0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({op0, busy0, done0} !== 3'b000) begin
                errors++; $display("FAIL abort_idle%0d got=%b exp=000", i, {op0, busy0, done0});
            end
        end
        din0 = 8'h01; load0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load0 = 1'b0;
            checks++; if ({op0, busy0, done0} !== {exp[11-i], 1'b1, (i == 11)}) begin
                errors++; $display("FAIL abort_bit%0d got=%b exp=%b", i, {op0, busy0, done0}, {exp[11-i], 1'b1, (i == 11)});
            end
        end
        @(negedge clk);
        checks++; if ({op0, busy0} !== 2'b00) begin
            errors++; $display("FAIL abort_after got=%b exp=00", {op0, busy0});
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_parity();
        test_back_to_back();
        test_load_ignored();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_seq_tx.md
Name: serial_seq_tx

Overview:
- Parallel-to-serial frame transmitter; the transmit end of the single-bit serial line that our sequence detectors consume.
- Accepts a DATA_W-bit word on a load/ready handshake.
- Emits on one output bit per clock: a fixed SYNC pattern, then the data MSB-first, then an optional even-parity bit.
- Sits upstream of a detector FSM; the detector's input bit is fed directly from op.

Parameters:
- DATA_W, 8: payload width in bits.
- SYNC_W, 4: sync pattern width in bits.
- SYNC, 4'b1011: sync pattern, sent MSB-first.
- PARITY_EN, 0: 1 appends an even-parity bit over the payload.
- IDLE_BIT, 1'b0: level driven on op when no frame is active.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- din, input, DATA_W: payload word; sampled only on acceptance.
- load, input, 1: request to send din.
- ready, output, 1: block can accept a load this cycle.
- op, output, 1: serial bit out, registered.
- busy, output, 1: a frame bit is currently on op.
- frame_done, output, 1: one-cycle pulse during the final bit of a frame.

Behaviour:
- Reset (reset=0, asynchronous, immediate regardless of clk):
  - State IDLE; op=IDLE_BIT, busy=0, frame_done=0.
  - ready=1; shift register and counter cleared.
  - A reset asserted mid-frame aborts the frame; no partial completion after release.
- Acceptance: load=1 and ready=1 at a rising edge. din is captured into the shift register; later changes to din have no effect on the frame.
- load while ready=0: ignored, no capture, no queuing.
- State machine: IDLE -> SYNC -> DATA -> (PARITY if PARITY_EN) -> IDLE.
  - IDLE: op=IDLE_BIT, busy=0. Acceptance moves to SYNC.
  - SYNC: SYNC_W cycles, op = SYNC[SYNC_W-1] down to SYNC[0].
  - DATA: DATA_W cycles, op = din[DATA_W-1] down to din[0].
  - PARITY: 1 cycle, op = XOR of all captured payload bits.
- Latency: op carries the first sync bit in the cycle after acceptance.
  - Frame length L = SYNC_W + DATA_W + PARITY_EN cycles.
  - busy=1 for exactly those L cycles.
- Last bit cycle (final DATA bit, or PARITY bit when enabled):
  - frame_done=1 for that cycle only.
  - ready=1 in that cycle, so a load accepted there starts SYNC next cycle with zero idle gap.
  - Without a load there, the next cycle returns to IDLE with op=IDLE_BIT.
- ready = (state==IDLE) OR last-bit cycle. It is combinational from registered state only, never from load.
- Counter:
  - Width $clog2(max(SYNC_W,DATA_W)+1).
  - Reloads at each phase boundary and counts down.
  - Must not wrap past 0 into a spurious extra bit.
- op, busy and frame_done are registered outputs, glitch-free.

Decomposition:
- Shared package serial_pkg holds:
  - State enum (IDLE, SYNC, DATA, PARITY).
  - Default SYNC constant and width.
  - Parity function (XOR reduce).
  The detector side imports the same SYNC constant.
- One sub-module, piso_shift:
  - Loadable parallel-in/serial-out shift register, parameterized width.
  - Ports: load, shift enable, MSB out.
  - Used once for the payload; the sync bits are indexed by the counter, not shifted.

Test Plan:
1. Reset held low mid-DATA -> op=0, busy=0, ready=1, frame_done=0 immediately. After release, op stays 0 with no frame until a load.
2. PARITY_EN=0, accept din=8'hA5 -> op over the next 12 cycles = 1,0,1,1, 1,0,1,0,0,1,0,1. frame_done high only in cycle 12; op=0 in cycle 13.
3. PARITY_EN=1, din=8'h07 -> 13-bit frame ending in payload 0,0,0,0,0,1,1,1 then parity bit 1. busy high for 13 cycles.
4. Back-to-back: load=1 with din=8'h3C during the frame_done cycle of an 8'hA5 frame -> the next cycle starts SYNC bit 1 with no IDLE gap, followed by 0,0,1,1,1,1,0,0.
5. load=1, din=8'hFF pulsed during the SYNC phase -> ignored; the original frame completes unchanged and no second frame follows.
6. Reset pulsed low during bit 6 of DATA, then accept din=8'h01 -> a clean full frame 1,0,1,1, 0,0,0,0,0,0,0,1 with no residue from the aborted frame.
